deser_arbiter: RTL and testbench

DESER_ARBITER -- requirements
Module: deser_arbiter

---
 rtl/deser_arbiter.sv | 113 +++++++++++
 tb/tb_deser_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/deser_arbiter.sv
// Round-robin arbiter that feeds one requester's serial bits into a shared deserializer and hands the byte to a consumer.
// Grant one cycle after request; byte held on byte_out until byte_accept; a granted requester silent for 63 cycles is aborted.
module deser_arbiter (
  input  logic       clk_100KHz,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       data_a,
  input  logic       data_b,
  input  logic       write_a,
  input  logic       write_b,
  output logic       grant_a,
  output logic       grant_b,
  output logic       deser_data_in,
  output logic       deser_write_in,
  output logic       deser_ack_in,
  input  logic       deser_status_out,
  input  logic       deser_data_ready,
  input  logic [7:0] deser_data_out,
  output logic [7:0] byte_out,
  output logic       byte_src,
  output logic       byte_valid,
  input  logic       byte_accept,
  output logic       timeout_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SHIFT    = 3'd1;
  localparam logic [2:0] S_WAIT_RDY = 3'd2;
  localparam logic [2:0] S_DELIVER  = 3'd3;
  localparam logic [2:0] S_ACK      = 3'd4;

  logic [2:0] r_state;
  logic       r_sel_b;
  logic       r_ptr_b;
  logic [2:0] r_bit_cnt;
  logic [5:0] r_stall;
  logic [7:0] r_byte;
  logic       r_src;

  logic w_shift;
  logic w_pick_b;
  logic w_strobe;
  logic w_timeout;

  assign w_shift   = (r_state == S_SHIFT);
  // B wins when it is alone, or when both ask and the pointer favours B.
  assign w_pick_b  = req_b & (~req_a | r_ptr_b);
  assign w_strobe  = w_shift & (r_sel_b ? write_b : write_a);
  assign w_timeout = w_shift & ~w_strobe & (r_stall == 6'd63);

  assign grant_a        = (r_state != S_IDLE) & ~r_sel_b;
  assign grant_b        = (r_state != S_IDLE) &  r_sel_b;
  assign deser_data_in  = w_shift & (r_sel_b ? data_b : data_a);
  assign deser_write_in = w_strobe;
  // The ack doubles as the flush pulse on abort.
  assign deser_ack_in   = (r_state == S_ACK) | w_timeout;
  assign timeout_err    = w_timeout;
  assign byte_valid     = (r_state == S_DELIVER);
  assign byte_out       = r_byte;
  assign byte_src       = r_src;

  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sel_b   <= 1'b0;
      r_ptr_b   <= 1'b0;
      r_bit_cnt <= 3'd0;
      r_stall   <= 6'd0;
      r_byte    <= 8'h00;
      r_src     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bit_cnt <= 3'd0;
          r_stall   <= 6'd0;
          if (deser_status_out && (req_a || req_b)) begin
            r_sel_b <= w_pick_b;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_strobe) begin
            r_stall   <= 6'd0;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= S_WAIT_RDY;
          end else if (w_timeout) begin
            r_ptr_b <= ~r_sel_b;
            r_state <= S_IDLE;
          end else begin
            r_stall <= r_stall + 6'd1;
          end
        end
        S_WAIT_RDY: begin
          if (deser_data_ready) begin
            r_byte  <= deser_data_out;
            r_src   <= r_sel_b;
            r_state <= S_DELIVER;
          end
        end
        S_DELIVER: begin
          if (byte_accept) r_state <= S_ACK;
        end
        S_ACK: begin
          r_ptr_b <= ~r_sel_b;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deser_arbiter.sv
// Randomized bench for deser_arbiter with a simple deserializer model and a round-robin reference.
module tb_deser_arbiter;

  logic       clk_100KHz = 1'b0;
  logic       reset;
  logic       req_a, req_b, data_a, data_b, write_a, write_b;
  logic       grant_a, grant_b, deser_data_in, deser_write_in, deser_ack_in;
  logic       deser_status_out, deser_data_ready;
  logic [7:0] deser_data_out;
  logic [7:0] byte_out;
  logic       byte_src, byte_valid, byte_accept, timeout_err;

  always #5 clk_100KHz = ~clk_100KHz;

  deser_arbiter dut (
    .clk_100KHz       (clk_100KHz),
    .reset            (reset),
    .req_a            (req_a),
    .req_b            (req_b),
    .data_a           (data_a),
    .data_b           (data_b),
    .write_a          (write_a),
    .write_b          (write_b),
    .grant_a          (grant_a),
    .grant_b          (grant_b),
    .deser_data_in    (deser_data_in),
    .deser_write_in   (deser_write_in),
    .deser_ack_in     (deser_ack_in),
    .deser_status_out (deser_status_out),
    .deser_data_ready (deser_data_ready),
    .deser_data_out   (deser_data_out),
    .byte_out         (byte_out),
    .byte_src         (byte_src),
    .byte_valid       (byte_valid),
    .byte_accept      (byte_accept),
    .timeout_err      (timeout_err)
  );

  // Deserializer: shifts in 8 bits MSB first, holds the byte until acked.
  logic [7:0] m_sh;
  logic [3:0] m_cnt;
  logic       m_rdy;
  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) begin
      m_sh <= 8'h00; m_cnt <= 4'd0; m_rdy <= 1'b0;
    end else if (deser_ack_in) begin
      m_cnt <= 4'd0; m_rdy <= 1'b0;
    end else if (deser_write_in && !m_rdy) begin
      m_sh  <= {m_sh[6:0], deser_data_in};
      m_cnt <= m_cnt + 4'd1;
      if (m_cnt == 4'd7) m_rdy <= 1'b1;
    end
  end
  assign deser_status_out = ~m_rdy;
  assign deser_data_ready = m_rdy;
  assign deser_data_out   = m_sh;

  int n_chk  = 0;
  int n_pass = 0;
  bit exp_ptr_b = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive_cycle(input bit win_b, input logic w, input logic d, input bit noisy);
    logic nw, nd;
    @(negedge clk_100KHz);
    nw = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    nd = 1'($urandom_range(0, 1));
    if (win_b) begin
      write_b = w; data_b = d; write_a = nw; data_a = nd;
    end else begin
      write_a = w; data_a = d; write_b = nw; data_b = nd;
    end
    #1;
    chk("wr_follow", 32'(deser_write_in), 32'(w));
    chk("data_follow", 32'(deser_data_in), 32'(d));
    chk("grant_held", 32'({grant_a, grant_b}), win_b ? 32'd1 : 32'd2);
  endtask

  // n_bits < 8 ends in a timeout abort unless do_rst, which resets mid-shift.
  task automatic run_txn(input bit ra, input bit rb, input logic [7:0] byte_a, input logic [7:0] byte_b,
                         input int n_bits, input int acc_wait, input bit noisy, input bit do_rst);
    bit win_b;
    logic [7:0] b;
    int k;
    win_b = (ra && rb) ? exp_ptr_b : rb;
    b = win_b ? byte_b : byte_a;
    @(negedge clk_100KHz);
    req_a = ra; req_b = rb;
    #1;
    chk("idle_quiet", 32'({grant_a, grant_b, deser_ack_in, byte_valid}), 32'd0);
    @(negedge clk_100KHz);
    req_a = 1'b0; req_b = 1'b0;
    #1;
    chk("grant", 32'({grant_a, grant_b}), win_b ? 32'd1 : 32'd2);
    for (int i = 0; i < n_bits; i++) begin
      repeat ($urandom_range(0, 2)) drive_cycle(win_b, 1'b0, 1'($urandom_range(0, 1)), noisy);
      drive_cycle(win_b, 1'b1, b[7-i], noisy);
    end
    @(negedge clk_100KHz);
    write_a = 1'b0; write_b = 1'b0;
    if (do_rst) begin
      reset = 1'b1;
      #1;
      chk("rst_outs", 32'({grant_a, grant_b, deser_write_in, deser_ack_in, byte_valid, timeout_err, byte_src}), 32'd0);
      chk("rst_byte", 32'(byte_out), 32'd0);
      @(negedge clk_100KHz);
      reset = 1'b0;
      exp_ptr_b = 1'b0;
      return;
    end
    #1;
    if (n_bits < 8) begin
      // Counting from the cycle after the last strobe; the pulse follows 63 silent cycles.
      k = 1;
      while (!timeout_err && k < 100) begin
        @(negedge clk_100KHz); #1; k++;
      end
      chk("to_delay", 32'(k), 32'd64);
      chk("to_ack", 32'(deser_ack_in), 32'd1);
      @(negedge clk_100KHz); #1;
      chk("to_drop", 32'({grant_a, grant_b, deser_ack_in, timeout_err}), 32'd0);
      exp_ptr_b = ~win_b;
      return;
    end
    k = 0;
    while (!byte_valid && k < 20) begin
      @(negedge clk_100KHz); #1; k++;
    end
    chk("valid_seen", 32'(byte_valid), 32'd1);
    chk("byte", 32'(byte_out), 32'(b));
    chk("src", 32'(byte_src), 32'(win_b));
    chk("no_ack_valid", 32'(deser_ack_in), 32'd0);
    repeat (acc_wait) begin
      @(negedge clk_100KHz); #1;
      chk("hold", 32'({byte_valid, deser_ack_in, byte_out}), 32'({1'b1, 1'b0, b}));
    end
    @(negedge clk_100KHz);
    byte_accept = 1'b1;
    #1;
    chk("accept_cyc", 32'({byte_valid, deser_ack_in}), 32'd2);
    @(negedge clk_100KHz);
    byte_accept = 1'b0;
    #1;
    chk("ack", 32'({deser_ack_in, byte_valid}), 32'd2);
    chk("ack_grant", 32'({grant_a, grant_b}), win_b ? 32'd1 : 32'd2);
    exp_ptr_b = ~win_b;
  endtask

  initial begin
    bit ra, rb;
    reset = 1'b1;
    req_a = 0; req_b = 0; data_a = 0; data_b = 0; write_a = 0; write_b = 0; byte_accept = 0;
    @(negedge clk_100KHz); #1;
    chk("reset_outs", 32'({grant_a, grant_b, deser_write_in, deser_ack_in, byte_valid, timeout_err, byte_src}), 32'd0);
    chk("reset_byte", 32'(byte_out), 32'd0);
    @(negedge clk_100KHz);
    reset = 1'b0;

    run_txn(1, 1, 8'h5A, 8'h3C, 8, 0, 0, 0);
    run_txn(1, 1, 8'h5A, 8'h3C, 8, 0, 0, 0);
    run_txn(1, 0, 8'hAD, 8'h00, 8, 1, 0, 0);
    run_txn(1, 0, 8'h96, 8'hFF, 8, 2, 1, 0);
    run_txn(0, 1, 8'h00, 8'hC3, 8, 20, 1, 0);
    run_txn(1, 0, 8'hE7, 8'h00, 3, 0, 0, 0);
    run_txn(1, 1, 8'h11, 8'h81, 8, 0, 0, 0);
    run_txn(1, 0, 8'hF0, 8'h00, 4, 0, 0, 1);
    run_txn(1, 0, 8'h69, 8'h00, 8, 1, 0, 0);

    for (int t = 0; t < 30; t++) begin
      ra = 1'($urandom_range(0, 1));
      rb = ra ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(ra, rb, 8'($urandom), 8'($urandom),
              ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 8,
              $urandom_range(0, 5), 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
